// File: rtl/switch_debouncer.sv
// Two-flop synchroniser plus per-bit stability counter for a raw switch bank; emits clean levels and rise/fall pulses.
// Latency: input stable from edge k appears on SWITCH_DB_O at edge k+1+DEBOUNCE_CYCLES; no backpressure, all outputs registered.
module switch_debouncer #(
  parameter int NUM_SW          = 18,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic              CLOCK_50_I,
  input  logic              RESET_I,
  input  logic [NUM_SW-1:0] SWITCH_I,
  output logic [NUM_SW-1:0] SWITCH_DB_O,
  output logic [NUM_SW-1:0] SWITCH_RISE_O,
  output logic [NUM_SW-1:0] SWITCH_FALL_O,
  output logic              CHANGE_O
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_SW-1:0] sync_a;
  logic [NUM_SW-1:0] sync_b;
  logic [CNT_W-1:0]  cnt     [NUM_SW];
  logic [CNT_W-1:0]  cnt_nxt [NUM_SW];
  logic [NUM_SW-1:0] db_nxt;
  logic [NUM_SW-1:0] rise_nxt;
  logic [NUM_SW-1:0] fall_nxt;

  // A single agreeing cycle clears the count, so any bounce restarts the window.
  always_comb begin
    db_nxt   = SWITCH_DB_O;
    rise_nxt = '0;
    fall_nxt = '0;
    for (int i = 0; i < NUM_SW; i++) begin
      cnt_nxt[i] = '0;
      if (sync_b[i] != SWITCH_DB_O[i]) begin
        if (cnt[i] == LAST) begin
          db_nxt[i]   = sync_b[i];
          rise_nxt[i] = sync_b[i];
          fall_nxt[i] = ~sync_b[i];
        end else begin
          cnt_nxt[i] = cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50_I) begin
    if (RESET_I) begin
      sync_a        <= '0;
      sync_b        <= '0;
      SWITCH_DB_O   <= '0;
      SWITCH_RISE_O <= '0;
      SWITCH_FALL_O <= '0;
      CHANGE_O      <= 1'b0;
      for (int i = 0; i < NUM_SW; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync_a        <= SWITCH_I;
      sync_b        <= sync_a;
      SWITCH_DB_O   <= db_nxt;
      SWITCH_RISE_O <= rise_nxt;
      SWITCH_FALL_O <= fall_nxt;
      CHANGE_O      <= |(rise_nxt | fall_nxt);
      for (int i = 0; i < NUM_SW; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

endmodule
